if_id_fetch_queue: RTL and testbench

Parametrised IF/ID boundary block that generalises the single IF/ID register into a DEPTH-entry FIFO of fetched instructions. It sits between the fetch unit (PC generation plus instruction memory or cache) and the decode stage. It lets fetch keep running while decode is stalled by data-cache busywait. It also discards all queued instructions in one cycle on a branch or jump redirect. Empty and flushed outputs read as zero, so decode sees a NOP-equivalent bubble.

---
 rtl/if_id_fetch_queue.sv | 77 +++++++
 tb/tb_if_id_fetch_queue.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_queue.sv
// IF/ID boundary FIFO: buffers fetched {PC, PC+4, instr} so fetch can run ahead of a
// stalled decode; a redirect empties it in one cycle and an empty queue reads as zero.
module if_id_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_4_in,
  input  logic [XLEN-1:0] instr_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_4_out,
  output logic [XLEN-1:0] instr_out,
  output logic [AW:0]     count,
  output logic            full,
  output logic            empty
);

  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [XLEN-1:0] r_pc_4_mem  [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_cnt;

  logic w_push;
  logic w_pop;
  logic w_clear;

  // in_ready depends only on registered occupancy, never on out_ready
  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign empty     = (r_cnt == '0);
  assign count     = r_cnt;
  assign in_ready  = !full;
  assign out_valid = !empty;

  assign w_clear = !reset || flush;
  assign w_push  = in_valid && in_ready && !w_clear;
  assign w_pop   = out_valid && out_ready && !w_clear;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is never cleared; empty gating below provides the zero bubble
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= pc_in;
      r_pc_4_mem[r_wr_ptr]  <= pc_4_in;
      r_instr_mem[r_wr_ptr] <= instr_in;
    end
  end

  assign pc_out    = empty ? '0 : r_pc_mem[r_rd_ptr];
  assign pc_4_out  = empty ? '0 : r_pc_4_mem[r_rd_ptr];
  assign instr_out = empty ? '0 : r_instr_mem[r_rd_ptr];

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed bench for if_id_fetch_queue: stimulus pushes expected entries into a
// scoreboard, a negedge monitor pops and compares whenever decode consumes the head.
module tb_if_id_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } ent_t;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, out_ready;
  logic            in_ready, out_valid, full, empty;
  logic [XLEN-1:0] pc_in, pc_4_in, instr_in, pc_out, pc_4_out, instr_out;
  logic [AW:0]     count;

  ent_t sb[$];
  int   m_cnt = 0;
  int   n_pass = 0;
  int   n_total = 0;

  if_id_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .pc_4_in(pc_4_in), .instr_in(instr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .pc_4_out(pc_4_out), .instr_out(instr_out),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] mk_instr(input logic [XLEN-1:0] pc);
    return {pc[15:0], 16'h0013};
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Decode-side monitor: consumes the scoreboard head on every real pop
  always @(negedge clk) begin
    if (reset === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pop: got pc 0x%0h expected no pop", pc_out);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("pop_pc",    pc_out,    e.pc);
        chk("pop_pc4",   pc_4_out,  e.pc4);
        chk("pop_instr", instr_out, e.instr);
      end
    end
  end

  // One clock of stimulus; model decides acceptance, then state is checked after the edge
  task automatic step(input logic rst_n, input logic fl, input logic iv, input logic ordy,
                      input logic [XLEN-1:0] pc);
    bit mpush, mpop;
    ent_t e;
    reset = rst_n; flush = fl; in_valid = iv; out_ready = ordy;
    pc_in = pc; pc_4_in = pc + 32'd4; instr_in = mk_instr(pc);
    mpush = rst_n && !fl && iv   && (m_cnt < DEPTH);
    mpop  = rst_n && !fl && ordy && (m_cnt > 0);
    if (mpush) begin
      e.pc = pc; e.pc4 = pc + 32'd4; e.instr = mk_instr(pc);
      sb.push_back(e);
    end
    if (!rst_n || fl) begin
      m_cnt = 0;
      sb.delete();
    end else begin
      m_cnt = m_cnt + int'(mpush) - int'(mpop);
    end
    @(posedge clk); #1;
    chk("count",     XLEN'(count),     XLEN'(m_cnt));
    chk("full",      XLEN'(full),      XLEN'(m_cnt == DEPTH));
    chk("empty",     XLEN'(empty),     XLEN'(m_cnt == 0));
    chk("in_ready",  XLEN'(in_ready),  XLEN'(m_cnt != DEPTH));
    chk("out_valid", XLEN'(out_valid), XLEN'(m_cnt != 0));
    if (m_cnt == 0) begin
      chk("zero_pc",    pc_out,    '0);
      chk("zero_pc4",   pc_4_out,  '0);
      chk("zero_instr", instr_out, '0);
    end else if (sb.size() > 0) begin
      chk("head_pc",    pc_out,    sb[0].pc);
      chk("head_pc4",   pc_4_out,  sb[0].pc4);
      chk("head_instr", instr_out, sb[0].instr);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = '0; pc_4_in = '0; instr_in = '0;
    // Power-on reset for 2 cycles, then fill
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 32'(i * 4));
    // Push while full is a no-op
    step(1, 0, 1, 0, 32'h10);
    // Stall: outputs must hold
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h0);
    // Drain; first cycle also offers a push that a full queue must refuse
    step(1, 0, 1, 1, 32'h50);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 32'h0);
    // Pop while empty is a no-op
    step(1, 0, 0, 1, 32'h0);
    step(1, 0, 0, 1, 32'h0);
    // Simultaneous push+pop at count 2 across pointer wrap
    step(1, 0, 1, 0, 32'h20);
    step(1, 0, 1, 0, 32'h24);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 1, 32'(32'h28 + i * 4));
    // Flush priority at count 3 with push and pop requested
    step(1, 0, 1, 0, 32'h40);
    step(1, 1, 1, 1, 32'h44);
    step(1, 0, 1, 0, 32'h100);
    step(1, 0, 1, 0, 32'h104);
    // Reset mid-operation at count 2
    step(0, 0, 1, 1, 32'h200);
    // Pointers intact: 4 push/pop values then drain
    for (int i = 0; i < 4; i++) step(1, 0, 1, (i > 0), 32'(32'h300 + i * 4));
    step(1, 0, 0, 1, 32'h0);
    step(1, 0, 0, 1, 32'h0);
    chk("sb_drained", XLEN'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
